// File: rtl/sdram_resp_pkg.sv
// Shared types and defaults for the SDRAM-port Avalon responder.
package sdram_resp_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    WR_HOLD = 1'b1
  } wr_state_e;

  localparam int unsigned LANE_W            = 8;
  localparam int unsigned DEF_ADDR_W        = 23;
  localparam int unsigned DEF_DATA_W        = 32;
  localparam int unsigned DEF_LANES         = DEF_DATA_W / LANE_W;
  localparam int unsigned DEF_MEM_AW        = 12;
  localparam int unsigned DEF_READ_LAT      = 3;
  localparam int unsigned DEF_WRITE_WAIT    = 1;
  localparam int unsigned DEF_STALL_PERIOD  = 7;

  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / LANE_W;
  endfunction

endpackage

// File: rtl/sdram_resp_rdpipe.sv
// Fixed-depth valid+data delay line for read returns; flushed by the async reset.
module sdram_resp_rdpipe #(
  parameter int unsigned LAT = 3,
  parameter int unsigned DW  = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic [LAT-1:0] valid_q;
  logic [DW-1:0]  data_q [LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      data_q[0]  <= data_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/sdram_avalon_responder.sv
// Avalon-MM slave speaking the SDRAM-controller port protocol, backed by on-chip RAM.
// Optional deterministic stall injection is enabled by defining SDRAM_RESP_STALL_INJECT_EN.
module sdram_avalon_responder
  import sdram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned MEM_AW       = DEF_MEM_AW,
  parameter int unsigned READ_LAT     = DEF_READ_LAT,
  parameter int unsigned WRITE_WAIT   = DEF_WRITE_WAIT,
  parameter int unsigned STALL_PERIOD = DEF_STALL_PERIOD
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [ADDR_W-1:0]             avs_address,
  input  logic [DATA_W/8-1:0]           avs_byteenable_n,
  input  logic                          avs_chipselect,
  input  logic [DATA_W-1:0]             avs_writedata,
  input  logic                          avs_read_n,
  input  logic                          avs_write_n,
  output logic [DATA_W-1:0]             avs_readdata,
  output logic                          avs_readdatavalid,
  output logic                          avs_waitrequest,
  output logic [$clog2(READ_LAT+1)-1:0] o_outstanding,
  output logic                          o_proto_err
);

  localparam int unsigned LANES  = lane_count(DATA_W);
  localparam int unsigned OUT_W  = $clog2(READ_LAT + 1);
  localparam int unsigned WCNT_W = $clog2(WRITE_WAIT + 2);

  wr_state_e         state_q, state_d;
  logic [WCNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic              proto_err_q, proto_err_d;

  logic              stall;
  logic              wr_req, rd_req, wr_wait, hold_block;
  logic              wr_acc, rd_acc, waitreq;
  logic              rd_valid_out;
  logic [MEM_AW-1:0] mem_idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem_q [2**MEM_AW];
  logic              addr_hi_unused;

`ifdef SDRAM_RESP_STALL_INJECT_EN
  localparam int unsigned STALL_W = $clog2(STALL_PERIOD);
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  assign stall       = (stall_cnt_q == STALL_W'(STALL_PERIOD - 1));
  assign stall_cnt_d = stall ? '0 : stall_cnt_q + STALL_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // A simultaneous read+write strobe is resolved as a write.
  assign wr_req     = avs_chipselect & ~avs_write_n;
  assign rd_req     = avs_chipselect & ~avs_read_n & avs_write_n;
  assign wr_wait    = (wr_cnt_q < WCNT_W'(WRITE_WAIT));
  // Leaving WR_HOLD costs one cycle, so anything else presented then waits.
  assign hold_block = (state_q == WR_HOLD) & ~wr_req;
  assign waitreq    = ~i_rst_n | stall | (wr_req & wr_wait) | hold_block;
  assign wr_acc     = wr_req & ~waitreq;
  assign rd_acc     = rd_req & ~waitreq;

  assign mem_idx        = avs_address[MEM_AW-1:0];
  assign addr_hi_unused = ^avs_address[ADDR_W-1:MEM_AW];

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_acc) begin
          wr_cnt_d = '0;
        end else if (wr_req) begin
          state_d = WR_HOLD;
          if (!stall) wr_cnt_d = wr_cnt_q + WCNT_W'(1);
        end
      end
      WR_HOLD: begin
        if (!wr_req || wr_acc) begin
          state_d  = IDLE;
          wr_cnt_d = '0;
        end else if (!stall) begin
          wr_cnt_d = wr_cnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        wr_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    proto_err_d   = proto_err_q | (avs_chipselect & ~avs_read_n & ~avs_write_n);
    outstanding_d = outstanding_q + OUT_W'(rd_acc) - OUT_W'(rd_valid_out);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      wr_cnt_q      <= '0;
      outstanding_q <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      outstanding_q <= outstanding_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // RAM contents survive reset; only enabled byte lanes are written.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (!avs_byteenable_n[i]) begin
          mem_q[mem_idx][i*LANE_W +: LANE_W] <= avs_writedata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign rd_word = mem_q[mem_idx];

  sdram_resp_rdpipe #(
    .LAT (READ_LAT),
    .DW  (DATA_W)
  ) u_rdpipe (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .valid_i (rd_acc),
    .data_i  (rd_word),
    .valid_o (rd_valid_out),
    .data_o  (avs_readdata)
  );

  assign avs_readdatavalid = rd_valid_out;
  assign avs_waitrequest   = waitreq;
  assign o_outstanding     = outstanding_q;
  assign o_proto_err       = proto_err_q;

endmodule

// File: tb/tb_sdram_avalon_responder.sv
// Directed self-checking bench for sdram_avalon_responder (READ_LAT=3, WRITE_WAIT=2).
module tb_sdram_avalon_responder;

  localparam int ADDR_W     = 23;
  localparam int DATA_W     = 32;
  localparam int READ_LAT   = 3;
  localparam int WRITE_WAIT = 2;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic [ADDR_W-1:0] avs_address;
  logic [3:0]        avs_byteenable_n;
  logic              avs_chipselect;
  logic [DATA_W-1:0] avs_writedata;
  logic              avs_read_n;
  logic              avs_write_n;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;
  logic              avs_waitrequest;
  logic [1:0]        o_outstanding;
  logic              o_proto_err;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  sdram_avalon_responder #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .MEM_AW       (12),
    .READ_LAT     (READ_LAT),
    .WRITE_WAIT   (WRITE_WAIT),
    .STALL_PERIOD (7)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .avs_address       (avs_address),
    .avs_byteenable_n  (avs_byteenable_n),
    .avs_chipselect    (avs_chipselect),
    .avs_writedata     (avs_writedata),
    .avs_read_n        (avs_read_n),
    .avs_write_n       (avs_write_n),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest),
    .o_outstanding     (o_outstanding),
    .o_proto_err       (o_proto_err)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    avs_chipselect = 1'b0;
    avs_read_n     = 1'b1;
    avs_write_n    = 1'b1;
  endtask

  // Present a write until accepted; returns waitrequest-high cycle count (10 = timeout).
  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic [3:0] ben, output int waits);
    waits = 0;
    avs_chipselect = 1'b1; avs_write_n = 1'b0; avs_read_n = 1'b1;
    avs_address = a; avs_writedata = d; avs_byteenable_n = ben;
    #1;
    while (avs_waitrequest && waits < 10) begin
      step();
      waits++;
    end
    step();
    idle();
    $display("write addr=%h data=%h be_n=%b waits=%0d", a, d, ben, waits);
  endtask

  // One-cycle read; returns cycles until readdatavalid (10 = timeout) and the data.
  task automatic read_word(input logic [ADDR_W-1:0] a, output int lat, output logic [31:0] d);
    lat = 1;
    avs_chipselect = 1'b1; avs_read_n = 1'b0; avs_write_n = 1'b1; avs_address = a;
    step();
    idle();
    while (!avs_readdatavalid && lat < 10) begin
      step();
      lat++;
    end
    d = avs_readdata;
    step();
    $display("read  addr=%h data=%h latency=%0d", a, d, lat);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    idle();
    avs_address = '0; avs_writedata = '0; avs_byteenable_n = '0;
    repeat (2) @(posedge i_clk);
    #1;
    total++; if (avs_readdatavalid !== 1'b0) begin bad++; $display("FAIL reset_rdv got=%b want=0", avs_readdatavalid); end
    total++; if (avs_readdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", avs_readdata); end
    total++; if (avs_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_waitreq got=%b want=1", avs_waitrequest); end
    total++; if (o_outstanding !== 2'd0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", o_outstanding); end
    total++; if (o_proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto_err got=%b want=0", o_proto_err); end
    i_rst_n = 1'b1;
    step();
    $display("reset checked");
  endtask

  task automatic test_read_latency();
    int w;
    int lat;
    write_word(23'd5, 32'hDEADBEEF, 4'b0000, w);
    total++; if (w !== WRITE_WAIT) begin bad++; $display("FAIL lat_write_waits got=%0d want=%0d", w, WRITE_WAIT); end
    avs_chipselect = 1'b1; avs_read_n = 1'b0; avs_write_n = 1'b1; avs_address = 23'd5;
    step();
    idle();
    total++; if (o_outstanding !== 2'd1) begin bad++; $display("FAIL lat_outstanding_1 got=%0d want=1", o_outstanding); end
    lat = 1;
    while (!avs_readdatavalid && lat < 10) begin step(); lat++; end
    total++; if (lat !== READ_LAT) begin bad++; $display("FAIL lat_cycles got=%0d want=%0d", lat, READ_LAT); end
    total++; if (avs_readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lat_data got=%h want=deadbeef", avs_readdata); end
    step();
    total++; if (o_outstanding !== 2'd0) begin bad++; $display("FAIL lat_outstanding_0 got=%0d want=0", o_outstanding); end
    total++; if (avs_readdatavalid !== 1'b0) begin bad++; $display("FAIL lat_single_pulse got=%b want=0", avs_readdatavalid); end
    $display("read latency lat=%0d", lat);
  endtask

  task automatic test_byte_mask();
    int w;
    int lat;
    logic [31:0] d;
    write_word(23'd7, 32'h11223344, 4'b0000, w);
    write_word(23'd7, 32'hAABBCCDD, 4'b1010, w);
    read_word(23'd7, lat, d);
    total++; if (d !== 32'h11BB33DD) begin bad++; $display("FAIL mask_data got=%h want=11bb33dd", d); end
    total++; if (lat !== READ_LAT) begin bad++; $display("FAIL mask_lat got=%0d want=%0d", lat, READ_LAT); end
  endtask

  task automatic test_write_wait();
    int lat;
    avs_chipselect = 1'b1; avs_write_n = 1'b0; avs_read_n = 1'b1;
    avs_address = 23'd9; avs_writedata = 32'h12345678; avs_byteenable_n = 4'b0000;
    #1;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (avs_waitrequest !== (c < 2)) begin
        bad++; $display("FAIL wait_cycle%0d got=%b want=%b", c, avs_waitrequest, (c < 2));
      end
      step();
    end
    idle();
    // Second write abandoned after one cycle; master switches to a read of the same word.
    avs_chipselect = 1'b1; avs_write_n = 1'b0; avs_writedata = 32'h5555AAAA;
    #1;
    total++; if (avs_waitrequest !== 1'b1) begin bad++; $display("FAIL abort_waitreq got=%b want=1", avs_waitrequest); end
    step();
    avs_write_n = 1'b1; avs_read_n = 1'b0;
    #1;
    total++; if (avs_waitrequest !== 1'b1) begin bad++; $display("FAIL hold_read_blocked got=%b want=1", avs_waitrequest); end
    step();
    total++; if (avs_waitrequest !== 1'b0) begin bad++; $display("FAIL idle_read_ready got=%b want=0", avs_waitrequest); end
    step();
    idle();
    lat = 1;
    while (!avs_readdatavalid && lat < 10) begin step(); lat++; end
    total++; if (lat !== READ_LAT) begin bad++; $display("FAIL abort_read_lat got=%0d want=%0d", lat, READ_LAT); end
    total++; if (avs_readdata !== 32'h12345678) begin bad++; $display("FAIL abort_ram_kept got=%h want=12345678", avs_readdata); end
    step();
    $display("write wait/abort done");
  endtask

  task automatic test_streaming();
    int w;
    int beats = 0;
    int peak = 0;
    logic [31:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      write_word(23'(i), 32'hA0000000 + 32'(i), 4'b0000, w);
    end
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        avs_chipselect = 1'b1; avs_read_n = 1'b0; avs_write_n = 1'b1; avs_address = 23'(c);
      end else begin
        idle();
      end
      #1;
      if (int'(o_outstanding) > peak) peak = int'(o_outstanding);
      if (avs_readdatavalid) begin
        exp_d = 32'hA0000000 + 32'(beats);
        total++;
        if (avs_readdata !== exp_d || c !== 3 + beats) begin
          bad++; $display("FAIL stream_beat%0d got=%h@cycle%0d want=%h@cycle%0d", beats, avs_readdata, c, exp_d, 3 + beats);
        end
        $display("beat %0d data=%h cycle=%0d", beats, avs_readdata, c);
        beats++;
      end
      step();
    end
    total++; if (beats !== 4) begin bad++; $display("FAIL stream_beats got=%0d want=4", beats); end
    total++; if (peak !== 3) begin bad++; $display("FAIL stream_peak got=%0d want=3", peak); end
    total++; if (o_outstanding !== 2'd0) begin bad++; $display("FAIL stream_drain got=%0d want=0", o_outstanding); end
  endtask

  task automatic test_wrap_err();
    int w;
    int lat;
    logic [31:0] d;
    write_word(23'h001005, 32'h00000001, 4'b0000, w);
    read_word(23'h000005, lat, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL wrap_data got=%h want=00000001", d); end
    total++; if (o_proto_err !== 1'b0) begin bad++; $display("FAIL err_before got=%b want=0", o_proto_err); end
    // Both strobes low: must behave as a write and latch the error.
    w = 0;
    avs_chipselect = 1'b1; avs_read_n = 1'b0; avs_write_n = 1'b0;
    avs_address = 23'h20; avs_writedata = 32'hCAFEF00D; avs_byteenable_n = 4'b0000;
    #1;
    while (avs_waitrequest && w < 10) begin step(); w++; end
    step();
    idle();
    total++; if (w !== WRITE_WAIT) begin bad++; $display("FAIL conflict_waits got=%0d want=%0d", w, WRITE_WAIT); end
    total++; if (o_proto_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", o_proto_err); end
    read_word(23'h20, lat, d);
    total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL conflict_write_data got=%h want=cafef00d", d); end
    total++; if (lat !== READ_LAT) begin bad++; $display("FAIL conflict_no_read got_lat=%0d want=%0d", lat, READ_LAT); end
    repeat (3) step();
    total++; if (o_proto_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", o_proto_err); end
    total++; if (o_outstanding !== 2'd0) begin bad++; $display("FAIL err_outstanding got=%0d want=0", o_outstanding); end
    i_rst_n = 1'b0;
    #1;
    total++; if (o_proto_err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b want=0", o_proto_err); end
    step();
    i_rst_n = 1'b1;
    step();
    $display("wrap/error done");
  endtask

  task automatic test_stall();
    int highs = 0;
    int accepted = 0;
    int beats = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 14) begin
        avs_chipselect = 1'b1; avs_read_n = 1'b0; avs_write_n = 1'b1; avs_address = 23'd0;
      end else begin
        idle();
      end
      #1;
      if (c < 14 && avs_waitrequest) highs++;
      if (c < 14 && !avs_waitrequest) accepted++;
      if (avs_readdatavalid) beats++;
      step();
    end
    total++; if (highs !== 2) begin bad++; $display("FAIL stall_cycles got=%0d want=2", highs); end
    total++; if (accepted !== 12) begin bad++; $display("FAIL stall_accepted got=%0d want=12", accepted); end
    total++; if (beats !== 12) begin bad++; $display("FAIL stall_beats got=%0d want=12", beats); end
    $display("stall highs=%0d beats=%0d", highs, beats);
  endtask

  initial begin
    test_reset();
`ifdef SDRAM_RESP_STALL_INJECT_EN
    test_stall();
`else
    test_read_latency();
    test_byte_mask();
    test_write_wait();
    test_streaming();
    test_wrap_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
